jt1943_sdram: RTL and testbench

SDRAM controller that sits directly downstream of the 1943 ROM slot sequencer. It runs the SDRAM power-up sequence and holds the sequencer in `loop_rst` until the device is usable. In play it turns each toggle of `sdram_re` into a single-word read, or into an auto-refresh when requested. During ROM download it turns `prog_we` pulses into single-word writes with periodic refresh.

---
 rtl/jt1943_sdram_pkg.sv | 31 +++
 rtl/jt1943_sdram_init.sv | 75 +++++++
 rtl/jt1943_sdram.sv | 205 ++++++++++++++++++++
 tb/tb_jt1943_sdram.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt1943_sdram_pkg.sv
// Shared definitions for the 1943 SDRAM controller: command encodings, FSM states, timing.
package jt1943_sdram_pkg;

  // {nCS, nRAS, nCAS, nWE}
  typedef logic [3:0] cmd_t;
  localparam cmd_t CMD_NOP   = 4'b0111;
  localparam cmd_t CMD_ACT   = 4'b0011;
  localparam cmd_t CMD_READ  = 4'b0101;
  localparam cmd_t CMD_WRITE = 4'b0100;
  localparam cmd_t CMD_PRE   = 4'b0010;
  localparam cmd_t CMD_REF   = 4'b0001;
  localparam cmd_t CMD_MRS   = 4'b0000;

  typedef enum logic [3:0] {
    ST_INIT_WAIT, ST_INIT_PRE, ST_INIT_REF1, ST_INIT_REF2, ST_INIT_MRS,
    ST_IDLE, ST_RCD, ST_RD, ST_CL, ST_CAP, ST_REF, ST_WR, ST_WR_WAIT
  } state_t;

  // Burst 1, sequential, CL2
  localparam logic [12:0] MODE_REG = 13'b000_0_00_010_0_000;

  localparam int TRCD = 2;
  localparam int TRFC = 7;
  localparam int TWRP = 4;

  // Column address with A10 set so every access auto-precharges.
  function automatic logic [12:0] col_ap(input logic [8:0] col);
    return {3'b001, 1'b0, col};
  endfunction

endpackage

// File: rtl/jt1943_sdram_init.sv
// SDRAM power-up sequencer: idle wait, precharge all, two refreshes, mode register load.
module jt1943_sdram_init
  import jt1943_sdram_pkg::*;
#(
  parameter int INIT_WAIT = 9600
) (
  input  logic        clk,
  input  logic        rst,
  output cmd_t        cmd_o,
  output logic [12:0] a_o,
  output logic        done_o,
  output state_t      state_o
);

  state_t      state_q;
  cmd_t        cmd_q;
  logic [12:0] a_q;
  logic [15:0] cnt_q;
  logic        done_q;

  // In each post-command state cnt_q counts the NOPs still owed before the next command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT_WAIT;
      cmd_q   <= CMD_NOP;
      a_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      cmd_q <= CMD_NOP;
      a_q   <= '0;
      case (state_q)
        ST_INIT_WAIT:
          if (cnt_q == 16'(INIT_WAIT - 1)) begin
            cmd_q   <= CMD_PRE;
            a_q     <= 13'h0400;
            cnt_q   <= 16'd2;
            state_q <= ST_INIT_PRE;
          end else cnt_q <= cnt_q + 16'd1;
        ST_INIT_PRE:
          if (cnt_q == '0) begin
            cmd_q   <= CMD_REF;
            cnt_q   <= 16'(TRFC);
            state_q <= ST_INIT_REF1;
          end else cnt_q <= cnt_q - 16'd1;
        ST_INIT_REF1:
          if (cnt_q == '0) begin
            cmd_q   <= CMD_REF;
            cnt_q   <= 16'(TRFC);
            state_q <= ST_INIT_REF2;
          end else cnt_q <= cnt_q - 16'd1;
        ST_INIT_REF2:
          if (cnt_q == '0) begin
            cmd_q   <= CMD_MRS;
            a_q     <= MODE_REG;
            cnt_q   <= 16'd2;
            state_q <= ST_INIT_MRS;
          end else cnt_q <= cnt_q - 16'd1;
        ST_INIT_MRS:
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else cnt_q <= cnt_q - 16'd1;
        ST_IDLE: done_q <= 1'b1;
        default: state_q <= ST_INIT_WAIT;
      endcase
    end
  end

  assign cmd_o   = cmd_q;
  assign a_o     = a_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: rtl/jt1943_sdram.sv
// Single-word SDRAM controller behind the 1943 ROM slot sequencer: reads in play,
// writes plus periodic refresh during ROM download.
module jt1943_sdram
  import jt1943_sdram_pkg::*;
#(
  parameter int INIT_WAIT  = 9600,
  parameter int REF_PERIOD = 740
) (
  input  logic        clk,
  input  logic        rst,
  output logic        loop_rst,
  input  logic        sdram_re,
  input  logic [21:0] sdram_addr,
  input  logic        autorefresh,
  output logic [15:0] data_read,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_we,
  output logic        prog_rdy,
  input  logic [15:0] SDRAM_DQ_in,
  output logic [15:0] SDRAM_DQ_out,
  output logic        SDRAM_DQ_oe,
  output logic [12:0] SDRAM_A,
  output logic [1:0]  SDRAM_BA,
  output logic        SDRAM_DQML,
  output logic        SDRAM_DQMH,
  output logic        SDRAM_nCS,
  output logic        SDRAM_nRAS,
  output logic        SDRAM_nCAS,
  output logic        SDRAM_nWE,
  output logic        SDRAM_CKE,
  output state_t      dbg_state
);

  // Handshakes: any edge on sdram_re differing from re_q is one read/refresh request,
  // acknowledged only by re_q catching up on acceptance; prog_we is a one-clock strobe
  // held in pend_q until served, and prog_rdy pulses for one clock once the write is done.

  cmd_t        init_cmd;
  logic [12:0] init_a;
  logic        init_done;
  state_t      init_state;

  jt1943_sdram_init #(.INIT_WAIT(INIT_WAIT)) u_init (
    .clk     (clk),
    .rst     (rst),
    .cmd_o   (init_cmd),
    .a_o     (init_a),
    .done_o  (init_done),
    .state_o (init_state)
  );

  state_t      state_q;
  cmd_t        cmd_q;
  logic [12:0] a_q;
  logic [1:0]  dqm_q;
  logic        dq_oe_q, prog_rdy_q, re_q, pend_q, op_write_q;
  logic [15:0] dq_out_q, data_read_q, pend_data_q, op_data_q;
  logic [21:0] pend_addr_q, op_addr_q;
  logic [1:0]  pend_mask_q, op_mask_q;
  logic [2:0]  cnt_q;
  logic [15:0] ref_cnt_q;

  logic        req, ref_due, wr_req;
  logic [21:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;

  assign req     = sdram_re != re_q;
  assign ref_due = ref_cnt_q == 16'(REF_PERIOD);
  assign wr_req  = pend_q | prog_we;
  assign wr_addr = pend_q ? pend_addr_q : prog_addr;
  assign wr_data = pend_q ? pend_data_q : prog_data;
  assign wr_mask = pend_q ? pend_mask_q : prog_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT_WAIT;
      cmd_q       <= CMD_NOP;
      a_q         <= '0;
      dqm_q       <= 2'b11;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
      data_read_q <= '0;
      prog_rdy_q  <= 1'b0;
      re_q        <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pend_mask_q <= '0;
      op_write_q  <= 1'b0;
      op_addr_q   <= '0;
      op_data_q   <= '0;
      op_mask_q   <= '0;
      cnt_q       <= '0;
      ref_cnt_q   <= '0;
    end else begin
      cmd_q      <= CMD_NOP;
      dq_oe_q    <= 1'b0;
      dqm_q      <= 2'b11;
      prog_rdy_q <= 1'b0;
      if (downloading) re_q <= sdram_re;
      if (prog_we) begin
        pend_q      <= 1'b1;
        pend_addr_q <= prog_addr;
        pend_data_q <= prog_data;
        pend_mask_q <= prog_mask;
      end
      if (!downloading) ref_cnt_q <= '0;
      else if (!ref_due) ref_cnt_q <= ref_cnt_q + 16'd1;
      case (state_q)
        ST_INIT_WAIT: if (init_done) state_q <= ST_IDLE;
        ST_IDLE:
          if (downloading) begin
            // Refresh wins; a coinciding write stays pending until the next IDLE.
            if (ref_due) begin
              cmd_q     <= CMD_REF;
              ref_cnt_q <= '0;
              cnt_q     <= 3'(TRFC - 1);
              state_q   <= ST_REF;
            end else if (wr_req) begin
              pend_q     <= pend_q & prog_we;
              op_write_q <= 1'b1;
              op_addr_q  <= wr_addr;
              op_data_q  <= wr_data;
              op_mask_q  <= wr_mask;
              cmd_q      <= CMD_ACT;
              a_q        <= wr_addr[21:9];
              cnt_q      <= 3'(TRCD - 2);
              state_q    <= ST_RCD;
            end
          end else if (req) begin
            re_q <= sdram_re;
            if (autorefresh) begin
              cmd_q   <= CMD_REF;
              cnt_q   <= 3'(TRFC - 1);
              state_q <= ST_REF;
            end else begin
              op_write_q <= 1'b0;
              op_addr_q  <= sdram_addr;
              cmd_q      <= CMD_ACT;
              a_q        <= sdram_addr[21:9];
              cnt_q      <= 3'(TRCD - 2);
              state_q    <= ST_RCD;
            end
          end
        ST_RCD:
          if (cnt_q == '0) state_q <= op_write_q ? ST_WR : ST_RD;
          else cnt_q <= cnt_q - 3'd1;
        ST_RD: begin
          cmd_q   <= CMD_READ;
          a_q     <= col_ap(op_addr_q[8:0]);
          dqm_q   <= 2'b00;
          cnt_q   <= 3'd1;
          state_q <= ST_CL;
        end
        ST_CL: begin
          dqm_q <= 2'b00;
          if (cnt_q == '0) state_q <= ST_CAP;
          else cnt_q <= cnt_q - 3'd1;
        end
        ST_CAP: begin
          data_read_q <= SDRAM_DQ_in;
          state_q     <= ST_IDLE;
        end
        ST_REF:
          if (cnt_q == '0) state_q <= ST_IDLE;
          else cnt_q <= cnt_q - 3'd1;
        ST_WR: begin
          cmd_q    <= CMD_WRITE;
          a_q      <= col_ap(op_addr_q[8:0]);
          dq_oe_q  <= 1'b1;
          dq_out_q <= op_data_q;
          dqm_q    <= ~op_mask_q;
          cnt_q    <= 3'(TWRP);
          state_q  <= ST_WR_WAIT;
        end
        ST_WR_WAIT:
          if (cnt_q == '0) begin
            prog_rdy_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else cnt_q <= cnt_q - 3'd1;
        default: state_q <= ST_INIT_WAIT;
      endcase
    end
  end

  cmd_t pin_cmd;
  assign pin_cmd = init_done ? cmd_q : init_cmd;

  assign {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE} = pin_cmd;
  assign SDRAM_A      = init_done ? a_q : init_a;
  assign SDRAM_BA     = 2'b00;
  assign SDRAM_CKE    = 1'b1;
  assign {SDRAM_DQMH, SDRAM_DQML} = dqm_q;
  assign SDRAM_DQ_oe  = dq_oe_q;
  assign SDRAM_DQ_out = dq_out_q;
  assign data_read    = data_read_q;
  assign prog_rdy     = prog_rdy_q;
  assign loop_rst     = ~init_done;
  assign dbg_state    = init_done ? state_q : init_state;

endmodule

// File: tb/tb_jt1943_sdram.sv
// Directed bench for jt1943_sdram with a small CL2 SDRAM model on the pins.
module tb_jt1943_sdram;
  import jt1943_sdram_pkg::*;

  localparam int W  = 9600;
  localparam int RP = 740;

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_READ = 4'b0101,
                         C_WRITE = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
                         C_MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        loop_rst, sdram_re = 1'b0, autorefresh = 1'b0, downloading = 1'b0;
  logic        prog_we = 1'b0, prog_rdy;
  logic [21:0] sdram_addr = '0, prog_addr = '0;
  logic [15:0] data_read, prog_data = '0, dq_in, dq_out;
  logic [1:0]  prog_mask = '0, ba;
  logic        dq_oe, dqml, dqmh, ncs, nras, ncas, nwe, cke;
  logic [12:0] a;
  state_t      dbg_state;
  logic [3:0]  cmd;

  assign cmd = {ncs, nras, ncas, nwe};

  always #5 clk = ~clk;

  jt1943_sdram #(.INIT_WAIT(W), .REF_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .loop_rst(loop_rst),
    .sdram_re(sdram_re), .sdram_addr(sdram_addr), .autorefresh(autorefresh),
    .data_read(data_read), .downloading(downloading),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_rdy(prog_rdy),
    .SDRAM_DQ_in(dq_in), .SDRAM_DQ_out(dq_out), .SDRAM_DQ_oe(dq_oe),
    .SDRAM_A(a), .SDRAM_BA(ba), .SDRAM_DQML(dqml), .SDRAM_DQMH(dqmh),
    .SDRAM_nCS(ncs), .SDRAM_nRAS(nras), .SDRAM_nCAS(ncas), .SDRAM_nWE(nwe),
    .SDRAM_CKE(cke), .dbg_state(dbg_state)
  );

  // SDRAM model: memory aliased on address[9:0], CL2 read data
  logic [15:0] mem [0:1023];
  logic        mem_init_q = 1'b0;
  logic [12:0] row_q = '0;
  logic        rd_p1 = 1'b0, rd_p2 = 1'b0;
  logic [9:0]  rd_a1 = '0, rd_a2 = '0;
  logic [9:0]  wr_idx;

  assign wr_idx = {row_q[0], a[8:0]};
  assign dq_in  = rd_p2 ? mem[rd_a2] : 16'h0000;

  always @(posedge clk) begin
    rd_p1 <= 1'b0;
    rd_p2 <= rd_p1;
    rd_a2 <= rd_a1;
    if (!mem_init_q) begin
      mem[10'h005] <= 16'hBEEF;
      mem[10'h010] <= 16'h5A5A;
      mem[10'h3FF] <= 16'hFFFF;
      mem_init_q   <= 1'b1;
    end
    if (cmd == C_ACT) row_q <= a;
    if (cmd == C_READ) begin
      rd_p1 <= 1'b1;
      rd_a1 <= {row_q[0], a[8:0]};
    end
    if (cmd == C_WRITE && dq_oe) begin
      if (!dqml) mem[wr_idx][7:0]  <= dq_out[7:0];
      if (!dqmh) mem[wr_idx][15:8] <= dq_out[15:8];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [3:0]  cmd_log [32];
  logic [12:0] a_log   [32];
  logic [1:0]  dqm_log [32];
  logic [15:0] dr_log  [32], dqo_log [32];
  logic        oe_log  [32], rdy_log [32];
  state_t      st_log  [32];

  // Samples n negedges starting with the current cycle; releases prog_we after one clock.
  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_log[i] = cmd;   a_log[i] = a;     dqm_log[i] = {dqmh, dqml};
      dr_log[i] = data_read; dqo_log[i] = dq_out; oe_log[i] = dq_oe;
      rdy_log[i] = prog_rdy; st_log[i] = dbg_state;
      if (i == 1) prog_we = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_loop_rst"}, loop_rst, 1'b1);
    check_eq({tag, "_cmd"}, cmd, C_NOP);
    check_eq({tag, "_cke"}, cke, 1'b1);
    check_eq({tag, "_a_ba"}, {a, ba}, 15'h0);
    check_eq({tag, "_dqm"}, {dqmh, dqml}, 2'b11);
    check_eq({tag, "_dq"}, {dq_oe, dq_out}, 17'h0);
    check_eq({tag, "_data_read"}, data_read, 16'h0);
    check_eq({tag, "_prog_rdy"}, prog_rdy, 1'b0);
    check_eq({tag, "_state"}, dbg_state, ST_INIT_WAIT);
  endtask

  // Called in the first cycle after reset is released.
  task automatic check_init(input string tag);
    int n = 0;
    int fall = -1;
    int cyc [4];
    logic [3:0]  cm [4];
    logic [12:0] am [4];
    for (int j = 0; j < 4; j++) begin cyc[j] = -1; cm[j] = C_NOP; am[j] = '0; end
    for (int k = 0; k < W + 40 && fall < 0; k++) begin
      @(negedge clk);
      if (!loop_rst) fall = k;
      else if (cmd != C_NOP) begin
        if (n < 4) begin cyc[n] = k; cm[n] = cmd; am[n] = a; end
        n++;
      end
    end
    check_eq({tag, "_ncmds"}, n, 4);
    check_eq({tag, "_pre"}, {cm[0], am[0][10]}, {C_PRE, 1'b1});
    check_eq({tag, "_pre_cyc"}, cyc[0], W);
    check_eq({tag, "_ref1"}, cm[1], C_REF);
    check_eq({tag, "_ref1_cyc"}, cyc[1], W + 3);
    check_eq({tag, "_ref2"}, cm[2], C_REF);
    check_eq({tag, "_ref2_cyc"}, cyc[2], W + 11);
    check_eq({tag, "_mrs"}, {cm[3], am[3]}, {C_MRS, 13'h0020});
    check_eq({tag, "_mrs_cyc"}, cyc[3], W + 19);
    check_eq({tag, "_loop_rst_fall"}, fall, W + 22);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nact, nread, nref, p2, nops;
    logic [3:0] ops [4];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 rst = 1'b0;
    check_init("init1");
    repeat (4) @(posedge clk);

    // Read row 0x012 col 0x005
    #1 sdram_addr = 22'h002405; sdram_re = ~sdram_re;
    observe(9);
    check_eq("rd_act", {cmd_log[1], a_log[1]}, {C_ACT, 13'h0012});
    check_eq("rd_cmd", {cmd_log[3], a_log[3]}, {C_READ, 13'h0405});
    check_eq("rd_dqm", dqm_log[3], 2'b00);
    check_eq("rd_data_n5", dr_log[5], 16'h0000);
    check_eq("rd_data_n6", dr_log[6], 16'hBEEF);
    check_eq("rd_idle_n6", st_log[6], ST_IDLE);

    // Autorefresh request, then a read exactly 8 clocks later
    @(posedge clk); #1 autorefresh = 1'b1; sdram_re = ~sdram_re;
    observe(8);
    nact = 0;
    for (int i = 1; i < 8; i++) if (cmd_log[i] == C_ACT) nact++;
    check_eq("ar_ref", cmd_log[1], C_REF);
    check_eq("ar_no_act", nact, 0);
    check_eq("ar_data_kept", dr_log[7], 16'hBEEF);
    @(posedge clk); #1 autorefresh = 1'b0; sdram_addr = 22'h000010; sdram_re = ~sdram_re;
    observe(8);
    check_eq("ar_next_act", {cmd_log[1], a_log[1]}, {C_ACT, 13'h0000});
    check_eq("ar_next_rd", {cmd_log[3], a_log[3]}, {C_READ, 13'h0410});
    check_eq("ar_next_data", dr_log[6], 16'h5A5A);

    // Download write with a simultaneous (ignored) sdram_re edge
    @(posedge clk);
    #1 downloading = 1'b1; prog_addr = 22'h0003FF; prog_data = 16'h1234;
    prog_mask = 2'b01; prog_we = 1'b1; sdram_re = ~sdram_re;
    observe(9);
    nread = 0;
    for (int i = 0; i < 9; i++) if (cmd_log[i] == C_READ) nread++;
    check_eq("wr_no_read", nread, 0);
    check_eq("wr_act", {cmd_log[1], a_log[1]}, {C_ACT, 13'h0001});
    check_eq("wr_cmd", {cmd_log[3], a_log[3]}, {C_WRITE, 13'h05FF});
    check_eq("wr_dqm", dqm_log[3], 2'b10);
    check_eq("wr_dq", {oe_log[3], dqo_log[3]}, {1'b1, 16'h1234});
    check_eq("wr_oe_off", oe_log[4], 1'b0);
    check_eq("wr_rdy_n7", rdy_log[7], 1'b0);
    check_eq("wr_rdy_n8", rdy_log[8], 1'b1);
    @(posedge clk); #1 downloading = 1'b0; sdram_addr = 22'h0003FF; sdram_re = ~sdram_re;
    observe(8);
    check_eq("wr_readback", dr_log[6], 16'hFF34);
    check_eq("wr_readback_lo", dr_log[6][7:0], 8'h34);

    // Download idle: periodic refresh, then a write colliding with a due refresh
    @(posedge clk); #1 downloading = 1'b1;
    nref = 0; p2 = -1;
    for (int i = 0; i < 2 * RP + 20; i++) begin
      @(negedge clk);
      if (cmd == C_REF) begin nref++; p2 = i; end
    end
    check_eq("dl_ref_count", nref, 2);
    if (p2 < 0) p2 = 2 * RP + 19;
    repeat (p2 + RP - (2 * RP + 19)) @(posedge clk);
    #1 prog_addr = 22'h000002; prog_data = 16'hCAFE; prog_mask = 2'b11; prog_we = 1'b1;
    observe(24);
    nops = 0;
    for (int j = 0; j < 4; j++) ops[j] = C_NOP;
    for (int i = 0; i < 24; i++)
      if (cmd_log[i] != C_NOP) begin
        if (nops < 4) ops[nops] = cmd_log[i];
        nops++;
      end
    check_eq("coll_first_ref", ops[0], C_REF);
    check_eq("coll_then_act", ops[1], C_ACT);
    check_eq("coll_then_write", ops[2], C_WRITE);
    check_eq("coll_rdy_16", {rdy_log[15], rdy_log[16]}, 2'b01);
    @(posedge clk); #1 downloading = 1'b0;

    // Reset while READ is on the pins
    @(posedge clk); #1 sdram_addr = 22'h002405; sdram_re = ~sdram_re;
    observe(3);
    @(posedge clk); #1;
    check_eq("rst_during_read", cmd, C_READ);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check_reset_vals("rst_mid");
    @(posedge clk); #1 rst = 1'b0;
    check_init("init2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
